// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 128-bit lines, fixed-latency refill from InstructionMemory.
// Define ICACHE_STATS_EN to add the HitCount/MissCount statistics outputs.
module icache_ctrl #(
   parameter int LINES       = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         CpuReq,
   input  logic [31:0]  CpuAddr,
   input  logic         Flush,
   output logic         CpuValid,
   output logic [31:0]  CpuIns,
   output logic         CpuBusy,
   output logic [31:0]  MemAddress,
   input  logic [127:0] MemData
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]  HitCount,
   output logic [31:0]  MissCount
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_RESP
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [LINES-1:0]   r_valid;
   logic [27:0]        r_tag  [LINES];
   logic [127:0]       r_data [LINES];

   logic [27:0]        r_blk;
   logic [1:0]         r_word;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_mem_addr;
   logic               r_cpu_valid;
   logic [31:0]        r_cpu_ins;

   logic [27:0]        w_req_blk;
   logic [IDX_W-1:0]   w_req_idx;
   logic [IDX_W-1:0]   w_lat_idx;
   logic               w_hit;
   logic               w_accept_hit;
   logic               w_accept_miss;
   logic               w_fill_done;
   logic               w_unused;

   assign w_req_blk = CpuAddr[31:4];
   assign w_req_idx = w_req_blk[IDX_W-1:0];
   assign w_lat_idx = r_blk[IDX_W-1:0];
   assign w_hit     = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_blk);
   assign w_unused  = ^CpuAddr[1:0];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_accept_hit  = 1'b0;
      w_accept_miss = 1'b0;
      w_fill_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (CpuReq) begin
               if (!Flush && w_hit) begin
                  w_accept_hit = 1'b1;
               end else begin
                  w_accept_miss = 1'b1;
                  w_state_nxt   = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (r_cnt == CNT_LAST) begin
               w_fill_done = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_valid     <= '0;
         r_blk       <= '0;
         r_word      <= '0;
         r_cnt       <= '0;
         r_mem_addr  <= '0;
         r_cpu_valid <= 1'b0;
         r_cpu_ins   <= '0;
      end else begin
         r_cpu_valid <= 1'b0;

         // A flush clears everything, but a line captured on the same edge still lands valid.
         if (Flush)       r_valid <= '0;
         if (w_fill_done) r_valid[w_lat_idx] <= 1'b1;

         if (w_accept_hit) begin
            r_cpu_valid <= 1'b1;
            r_cpu_ins   <= r_data[w_req_idx][{CpuAddr[3:2], 5'b0} +: 32];
         end

         if (w_accept_miss) begin
            r_blk      <= w_req_blk;
            r_word     <= CpuAddr[3:2];
            r_cnt      <= '0;
            r_mem_addr <= {4'b0, w_req_blk};
         end

         if (r_state == S_FILL) begin
            if (w_fill_done) r_cnt <= '0;
            else             r_cnt <= r_cnt + CNT_W'(1);
         end

         if (r_state == S_RESP) begin
            r_cpu_valid <= 1'b1;
            r_cpu_ins   <= r_data[w_lat_idx][{r_word, 5'b0} +: 32];
         end
      end
   end

   // NOTE: tag/data arrays are not reset; the cleared valid bits make their contents irrelevant.
   always_ff @(posedge CLK) begin
      if (w_fill_done) begin
         r_tag[w_lat_idx]  <= r_blk;
         r_data[w_lat_idx] <= MemData;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         HitCount  <= '0;
         MissCount <= '0;
      end else begin
         if (w_accept_hit)  HitCount  <= HitCount + 32'd1;
         if (w_accept_miss) MissCount <= MissCount + 32'd1;
      end
   end
`endif

   assign CpuValid   = r_cpu_valid;
   assign CpuIns     = r_cpu_ins;
   assign CpuBusy    = (r_state != S_IDLE);
   assign MemAddress = r_mem_addr;

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache controller in front of the InstructionMemory block (128-bit line, 4 x 32-bit words).
- Serves 32-bit instruction fetches from the CPU fetch stage.
- On a miss, sequences a line refill from InstructionMemory with a fixed wait, installs the line and returns the word.
- Sits between the PC/fetch stage and InstructionMemory.

Parameters:
- LINES, 8, number of cache lines; power of 2, minimum 2.
- MEM_LATENCY, 2, CLK cycles from driving MemAddress until MemData is valid; minimum 1.

Ports:
- CLK  input  1  clock, rising edge.
- RSTn  input  1  asynchronous active-low reset.
- CpuReq  input  1  fetch request; sampled only when CpuBusy=0.
- CpuAddr  input  32  byte address; block = CpuAddr[31:4]; word select = CpuAddr[3:2].
- Flush  input  1  invalidate all lines.
- CpuValid  output  1  one-cycle pulse; CpuIns is valid.
- CpuIns  output  32  fetched instruction.
- CpuBusy  output  1  high whenever state != IDLE.
- MemAddress  output  32  block address to InstructionMemory, {4'b0, block}.
- MemData  input  128  line from InstructionMemory; word 0 is bits [31:0].

Behaviour:
- Reset (async, RSTn=0):
  - state=IDLE.
  - All valid bits=0.
  - CpuValid=0, CpuIns=0, CpuBusy=0, MemAddress=0.
  - Wait counter=0.
  - Latched request cleared.
- Reset mid-refill aborts the refill; no line is installed.
- Storage per line: valid bit, stored block number (28 bits), 128-bit data.
  - index = block[log2(LINES)-1:0].
  - hit = valid[index] && stored_block[index]==block.
- IDLE:
  - If CpuReq=1 at a rising edge, latch CpuAddr and evaluate hit against the state before the edge.
  - Hit: next cycle CpuValid=1, CpuIns = line[32*w +: 32]; stay IDLE. Hit latency is 1 cycle.
  - Back-to-back hits are accepted every cycle.
  - Miss: go to FILL; MemAddress = latched block, held stable until FILL exits.
- FILL:
  - Counter counts 0..MEM_LATENCY-1.
  - At the edge where counter==MEM_LATENCY-1, capture MemData into line[index], set stored_block, set valid=1, and go to RESP.
- RESP:
  - Exactly one cycle: CpuValid=1, CpuIns = selected word of the captured line.
  - Next state IDLE; CpuBusy=0 in the following cycle.
  - Miss latency, request edge to CpuValid: MEM_LATENCY+2 cycles.
- CpuValid:
  - Pulses exactly once per accepted request.
  - 0 in all other cycles.
  - CpuIns holds its last value when CpuValid=0.
- CpuReq while CpuBusy=1 is ignored; the requester must re-present it.
- Flush:
  - Clears all valid bits at the next edge, in any state.
  - Flush and CpuReq in the same IDLE cycle: flush wins; the request is treated as a miss.
  - Flush during FILL: valid bits clear, the refill still completes and installs its line as valid.
  - Flush in the same edge as the FILL capture: the captured line ends valid, all others invalid.
- Conflict: a new block with the same index replaces the old line; no write-back, since the cache is read-only.
- Address wrap: block 0x0FFFFFFF is handled normally; MemAddress upper 4 bits are always 0.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs HitCount[31:0] and MissCount[31:0], both reset to 0.
  - HitCount increments on each IDLE hit.
  - MissCount increments on each IDLE to FILL transition.
  - Both wrap at 2^32; Flush does not clear them.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then CpuReq with CpuAddr=0x00000004; memory returns line 0x44444444_33333333_22222222_11111111 -> MemAddress=0x0; CpuValid after 4 cycles (MEM_LATENCY=2), CpuIns=0x22222222.
- Repeat fetch at 0x0000000C right after -> hit; CpuValid next cycle, CpuIns=0x44444444, MemAddress unchanged, CpuBusy stays 0.
- Fetch 0x00000080 (block 8, index 0 with LINES=8) then 0x00000000 -> both miss, two refills with MemAddress=0x8 then 0x0; with ICACHE_STATS_EN, MissCount=2.
- Assert Flush during a FILL for 0x10, then re-fetch 0x10 and 0x00 -> 0x10 hits (1 cycle), 0x00 misses.
- Drop RSTn for half a cycle mid-FILL -> CpuBusy=0 and CpuValid=0 immediately; no CpuValid pulse; a subsequent fetch of the same address misses.
- CpuReq held high while busy -> exactly one CpuValid per accepted request; the ignored request produces no response.
